// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT sequencer types and control-bit positions
package fft_pkg;

    typedef enum logic [1:0] {
        FFT_SEQ_IDLE  = 2'd0,
        FFT_SEQ_ISSUE = 2'd1,
        FFT_SEQ_DRAIN = 2'd2
    } fft_seq_state_t;

    // Bit positions inside ictrl/octrl, shared with the butterfly and writeback stage
    localparam int FFT_CTRL_FIRST = 0;
    localparam int FFT_CTRL_LAST  = 1;

endpackage

// File: rtl/fft_delay_line.sv
// rtl/fft_delay_line.sv - async-reset shift register aligning issue info to read data
module fft_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign data_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - issues the N/2 butterflies of one DIF stage and reports completion
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int  FFT_N     = 10,
    parameter int  FFT_STAGE = 0,
    parameter int  RD_LAT    = 1,
    localparam int KW        = (FFT_N > 1) ? FFT_N - 1 : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [FFT_N-1:0] rd_addr_a,
    output logic [FFT_N-1:0] rd_addr_b,
    output logic [KW-1:0]    tw_addr,
    output logic             bf_iact,
    output logic [1:0]       bf_ictrl,
    output logic [KW-1:0]    bf_addr,
    input  logic             bf_oact,
    input  logic [1:0]       bf_octrl
);

    localparam int               P        = FFT_N - 1 - FFT_STAGE;
    localparam int               HALF     = 1 << (FFT_N - 1);
    localparam logic [FFT_N-1:0] SPAN     = FFT_N'(1 << P);
    localparam logic [FFT_N-1:0] LOW_MASK = SPAN - FFT_N'(1);
    localparam int               DW       = 1 + 2 + KW;

    fft_seq_state_t   state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             busy_q, done_q, done_d, rd_en_q;
    logic [FFT_N-1:0] addr_a_q, addr_b_q;
    logic [KW-1:0]    tw_q, kout_q;
    logic [1:0]       ctrl_q;

    logic             issue, last_k;
    logic [FFT_N-1:0] k_ext, addr_a_d, addr_b_d;
    logic [KW-1:0]    tw_d;
    logic [1:0]       ctrl_d;
    logic             octrl_unused;

    assign octrl_unused = bf_octrl[FFT_CTRL_FIRST];

    // Start issues k=0 on the same edge it is sampled, so the first read lands one cycle later
    assign issue  = ((state_q == FFT_SEQ_IDLE) && start) || ((state_q == FFT_SEQ_ISSUE) && !hold);
    assign last_k = (k_q == KW'(HALF - 1));

    // Insert a zero at bit P to get the A operand; B is its partner one span above
    assign k_ext    = FFT_N'(k_q);
    assign addr_a_d = ((k_ext >> P) << (P + 1)) | (k_ext & LOW_MASK);
    assign addr_b_d = addr_a_d + SPAN;
    assign tw_d     = KW'((k_ext & LOW_MASK) << FFT_STAGE);

    always_comb begin
        ctrl_d                 = '0;
        ctrl_d[FFT_CTRL_FIRST] = (k_q == '0);
        ctrl_d[FFT_CTRL_LAST]  = last_k;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        done_d  = 1'b0;
        case (state_q)
            FFT_SEQ_IDLE, FFT_SEQ_ISSUE: begin
                if (issue) begin
                    k_d     = last_k ? '0 : k_q + 1'b1;
                    state_d = last_k ? FFT_SEQ_DRAIN : FFT_SEQ_ISSUE;
                end
            end
            FFT_SEQ_DRAIN: begin
                if (bf_oact && bf_octrl[FFT_CTRL_LAST]) begin
                    state_d = FFT_SEQ_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = FFT_SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FFT_SEQ_IDLE;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
            kout_q   <= '0;
            ctrl_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            busy_q  <= (state_d != FFT_SEQ_IDLE);
            done_q  <= done_d;
            rd_en_q <= issue;
            ctrl_q  <= issue ? ctrl_d : 2'b00;
            if (issue) begin
                addr_a_q <= addr_a_d;
                addr_b_q <= addr_b_d;
                tw_q     <= tw_d;
                kout_q   <= k_q;
            end
        end
    end

    fft_delay_line #(
        .WIDTH (DW),
        .DEPTH (RD_LAT)
    ) u_align (
        .clk    (clk),
        .reset  (reset),
        .data_i ({rd_en_q, ctrl_q, kout_q}),
        .data_o ({bf_iact, bf_ictrl, bf_addr})
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = addr_a_q;
    assign rd_addr_b = addr_b_q;
    assign tw_addr   = tw_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - directed table checks of three FFT_N=4 sequencer instances
module tb_fft_stage_sequencer;

    localparam int NREC = 30;

    logic clk = 1'b0;
    logic reset, start, hold, stray;
    always #5 clk = ~clk;

    logic [2:0]       busy_v, done_v, rd_en_v, iact_v, oact_v;
    logic [2:0][3:0]  a_v, b_v;
    logic [2:0][2:0]  tw_v, baddr_v;
    logic [2:0][1:0]  ictrl_v, octrl_v;

    // Instance 0: stage 0, RD_LAT 1; 1: stage 2, RD_LAT 1; 2: stage 0, RD_LAT 2
    for (genvar d = 0; d < 3; d++) begin : g_dut
        fft_stage_sequencer #(
            .FFT_N     (4),
            .FFT_STAGE ((d == 1) ? 2 : 0),
            .RD_LAT    ((d == 2) ? 2 : 1)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .hold      (hold),
            .busy      (busy_v[d]),
            .done      (done_v[d]),
            .rd_en     (rd_en_v[d]),
            .rd_addr_a (a_v[d]),
            .rd_addr_b (b_v[d]),
            .tw_addr   (tw_v[d]),
            .bf_iact   (iact_v[d]),
            .bf_ictrl  (ictrl_v[d]),
            .bf_addr   (baddr_v[d]),
            .bf_oact   (oact_v[d]),
            .bf_octrl  (octrl_v[d])
        );

        // Butterfly stand-in: 6-cycle delay of iact/ictrl, plus a stray-pulse override on instance 0
        logic [5:0]  pa;
        logic [11:0] pc;
        logic        stray_here;
        always @(posedge clk or posedge reset) begin
            if (reset) begin
                pa <= '0;
                pc <= '0;
            end else begin
                pa <= {pa[4:0], iact_v[d]};
                pc <= {pc[9:0], ictrl_v[d]};
            end
        end
        assign stray_here  = stray && (d == 0);
        assign oact_v[d]   = pa[5] | stray_here;
        assign octrl_v[d]  = stray_here ? 2'b00 : pc[11:10];
    end

    logic [2:0]      r_rd [NREC], r_iact [NREC], r_done [NREC], r_busy [NREC];
    logic [2:0][3:0] r_a [NREC], r_b [NREC];
    logic [2:0][2:0] r_tw [NREC], r_baddr [NREC];
    logic [2:0][1:0] r_ctrl [NREC];

    typedef struct packed {
        logic [3:0] a0, b0;
        logic [2:0] tw0;
        logic [3:0] a1, b1;
        logic [2:0] tw1;
        logic [1:0] ctrl;
    } vec_t;
    vec_t vecs [8];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_out(input int d);
        return 32'({busy_v[d], done_v[d], rd_en_v[d], a_v[d], b_v[d], tw_v[d],
                    iact_v[d], ictrl_v[d], baddr_v[d]});
    endfunction

    task automatic record(input int t);
        r_rd[t]    = rd_en_v;
        r_iact[t]  = iact_v;
        r_done[t]  = done_v;
        r_busy[t]  = busy_v;
        r_a[t]     = a_v;
        r_b[t]     = b_v;
        r_tw[t]    = tw_v;
        r_baddr[t] = baddr_v;
        r_ctrl[t]  = ictrl_v;
    endtask

    // Cycle t is the interval after edge t-1; inputs set in cycle t are sampled at edge t
    task automatic run_stage(input int hold_lo, input int hold_hi, input int start_again, input int stray_at);
        @(negedge clk);
        start = 1'b1;
        record(0);
        for (int t = 1; t < NREC; t++) begin
            @(negedge clk);
            record(t);
            start = (t == start_again);
            hold  = (t >= hold_lo) && (t <= hold_hi);
            stray = (t == stray_at);
        end
        start = 1'b0;
        hold  = 1'b0;
        stray = 1'b0;
    endtask

    function automatic int first_done(input int d);
        for (int t = 0; t < NREC; t++) begin
            if (r_done[t][d]) return t;
        end
        return -1;
    endfunction

    function automatic int rd_count(input int d);
        int n = 0;
        for (int t = 0; t < NREC; t++) begin
            if (r_rd[t][d]) n++;
        end
        return n;
    endfunction

    function automatic logic held_run_rd(input int t);
        return ((t >= 1) && (t <= 2)) || ((t >= 5) && (t <= 10));
    endfunction

    initial begin
        vecs[0] = '{4'd0, 4'd8,  3'd0, 4'd0,  4'd2,  3'd0, 2'b01};
        vecs[1] = '{4'd1, 4'd9,  3'd1, 4'd1,  4'd3,  3'd4, 2'b00};
        vecs[2] = '{4'd2, 4'd10, 3'd2, 4'd4,  4'd6,  3'd0, 2'b00};
        vecs[3] = '{4'd3, 4'd11, 3'd3, 4'd5,  4'd7,  3'd4, 2'b00};
        vecs[4] = '{4'd4, 4'd12, 3'd4, 4'd8,  4'd10, 3'd0, 2'b00};
        vecs[5] = '{4'd5, 4'd13, 3'd5, 4'd9,  4'd11, 3'd4, 2'b00};
        vecs[6] = '{4'd6, 4'd14, 3'd6, 4'd12, 4'd14, 3'd0, 2'b00};
        vecs[7] = '{4'd7, 4'd15, 3'd7, 4'd13, 4'd15, 3'd4, 2'b10};

        reset = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        stray = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check($sformatf("reset outputs u%0d", d), all_out(d), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Unheld walk with a start pulse in mid-ISSUE that must be ignored
        run_stage(99, 99, 4, 99);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("A u0 map k%0d", k),
                  {r_rd[k+1][0], r_a[k+1][0], r_b[k+1][0], r_tw[k+1][0]},
                  {1'b1, vecs[k].a0, vecs[k].b0, vecs[k].tw0});
            check($sformatf("A u1 map k%0d", k),
                  {r_rd[k+1][1], r_a[k+1][1], r_b[k+1][1], r_tw[k+1][1]},
                  {1'b1, vecs[k].a1, vecs[k].b1, vecs[k].tw1});
            check($sformatf("A u0 bf k%0d", k),
                  {r_iact[k+2][0], r_baddr[k+2][0], r_ctrl[k+2][0]}, {1'b1, 3'(k), vecs[k].ctrl});
            check($sformatf("A u2 bf k%0d", k),
                  {r_iact[k+3][2], r_baddr[k+3][2], r_ctrl[k+3][2]}, {1'b1, 3'(k), vecs[k].ctrl});
        end
        check("A u0 rd_en count", rd_count(0), 8);
        check("A u0 done cycle", first_done(0), 16);
        check("A u1 done cycle", first_done(1), 16);
        check("A u2 done cycle", first_done(2), 17);
        check("A u0 busy fall", {r_busy[15][0], r_busy[16][0], r_done[17][0]}, 3'b100);

        // Hold sampled at edges 2..3 gives bubbles in cycles 3..4; stray oact at cycle 11 in DRAIN
        run_stage(2, 3, 0, 11);
        begin
            int idx0 = 0;
            int idx2 = 0;
            for (int t = 1; t < NREC; t++) begin
                check($sformatf("B u0 rd_en c%0d", t), r_rd[t][0], held_run_rd(t));
                check($sformatf("B u2 iact c%0d", t), r_iact[t][2], (t >= 3) ? held_run_rd(t - 2) : 1'b0);
                if (r_rd[t][0]) begin
                    check($sformatf("B u0 k seq c%0d", t), r_a[t][0], idx0);
                    idx0++;
                end
                if (r_iact[t][2]) begin
                    check($sformatf("B u2 bf_addr c%0d", t), r_baddr[t][2], idx2);
                    idx2++;
                end
            end
            check("B u0 issued", idx0, 8);
            check("B u2 bf issued", idx2, 8);
        end
        check("B u0 busy after stray", {r_busy[12][0], r_done[12][0]}, 2'b10);
        check("B u0 done cycle", first_done(0), 18);
        check("B u2 done cycle", first_done(2), 19);

        // Asynchronous reset while k=4 is on the read port
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("C k4 before reset", {rd_en_v[0], a_v[0]}, {1'b1, 4'd4});
        #1 reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) check($sformatf("C async reset u%0d", d), all_out(d), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen = 0;
            for (int t = 0; t < 12; t++) begin
                @(negedge clk);
                if (done_v != 3'b000 || busy_v != 3'b000) seen++;
            end
            check("C no done after abort", seen, 0);
        end

        run_stage(99, 99, 99, 99);
        check("D first issue", {r_rd[1][0], r_a[1][0], r_b[1][0]}, {1'b1, 4'd0, 4'd8});
        check("D first bf", {r_iact[2][0], r_baddr[2][0], r_ctrl[2][0]}, {1'b1, 3'd0, 2'b01});
        check("D rd_en count", rd_count(0), 8);
        check("D done cycle", first_done(0), 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
